timing_state_gen: RTL
=====================

TIMING_STATE_GEN -- requirements
Module: timing_state_gen

Interface
REQ-001 SHALL have port CLK  input  1  the single system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-003 SHALL have port T_0  input  1  beat-restart request from the control signal generator (end of machine cycle).
REQ-004 SHALL have port T_1  input  1  beat-advance request from the control signal generator.
REQ-005 SHALL have ports FI0, SRC0, DST0, EXC0  input  1 each  next-machine-cycle requests, meaningful only with T_0.
REQ-006 SHALL have port HALT0  input  1  halt request, meaningful only with T_0.
REQ-007 SHALL have port START  input  1  leave the halted state.
REQ-008 SHALL have ports t0..t11  output  1 each  one-hot beat pulses, registered.
REQ-009 SHALL have ports FI, SRC, DST, EXC  output  1 each  one-hot machine-cycle status, registered.
REQ-010 SHALL have port HALTED  output  1  high while halted.
REQ-011 SHALL have port TERR  output  1  one-cycle pulse on beat overrun.
REQ-012 SHALL have port WDT_TO  output  1  one-cycle watchdog pulse; tied 0 when the watchdog is compiled out.

Function
REQ-013 Outside HALTED, exactly one of t0..t11 and exactly one of FI/SRC/DST/EXC SHALL be high in every cycle.
REQ-014 T_0=1: next beat = t0; next cycle state = highest-priority asserted request, priority FI0>SRC0>DST0>EXC0.
REQ-015 T_0=1 with no request asserted: the current cycle state SHALL be kept and the beat SHALL restart at t0.
REQ-016 T_0 and T_1 both high: T_0 SHALL win and T_1 SHALL be ignored.
REQ-017 T_1=1 and T_0=0: beat tn -> tn+1 on the next clock, for n=0..10.
REQ-018 T_1=1 at t11: beat SHALL stay at t11 (no wrap) and TERR SHALL pulse for one cycle.
REQ-019 T_0=T_1=0: beat and state SHALL hold; this is a wait state of unlimited length unless the watchdog is enabled.
REQ-020 T_0=1 with HALT0=1: HALTED=1 and all t* and cycle outputs 0 on the next clock; HALT0 overrides FI0..EXC0.
REQ-021 While HALTED, T_0, T_1, FI0..EXC0 and HALT0 SHALL be ignored.
REQ-022 START=1 while HALTED: next clock HALTED=0, FI=1, t0=1.
REQ-023 START=1 while not HALTED SHALL have no effect.
REQ-024 Latency of every request to its output SHALL be exactly one clock; no output SHALL be combinational from an input.

Reset
REQ-025 RST=1 SHALL, on the next clock, set FI=1 and t0=1, and clear SRC, DST, EXC, t1..t11, HALTED, TERR, WDT_TO and the watchdog count.
REQ-026 RST SHALL override every other input in the same cycle, including mid-wait-state and while HALTED.

Configuration
REQ-027 Macro TIMING_WATCHDOG_EN SHALL control a 4-bit idle counter.
REQ-028 With TIMING_WATCHDOG_EN defined, the counter SHALL increment on each non-halted cycle with T_0=T_1=0 and clear on T_0, T_1, START or HALTED.
REQ-029 With TIMING_WATCHDOG_EN defined, a counter value of 15 with another idle cycle SHALL force FI=1, t0=1 and a one-cycle WDT_TO pulse on the next clock, and clear the counter.
REQ-030 Without TIMING_WATCHDOG_EN, no counter SHALL exist, WDT_TO SHALL be constant 0, and idle lasts indefinitely.

Structure
REQ-031 A shared package SHALL hold: the beat-count constant (12), the cycle-state one-hot encodings (FI, SRC, DST, EXC), the halt encoding, and the watchdog limit (15).
REQ-032 The one-hot beat ring (restart/advance/hold plus overrun flag) SHALL be sub-module beat_ring; cycle-state, halt and watchdog logic SHALL stay in timing_state_gen.

Verification
REQ-033 Reset, then two cycles of T_1 -> FI=1, t2=1; then T_0 with DST0 -> DST=1, t0=1.
REQ-034 At t11, T_1=1 -> t11 stays 1 and TERR is high for exactly one cycle.
REQ-035 T_0 with FI0, SRC0 and EXC0 all high, plus T_1 -> FI=1, t0=1 (priority rule and T_0 wins).
REQ-036 T_0 with HALT0 and FI0 -> HALTED=1 and all t*/state outputs 0; T_0/T_1 then ignored; START -> FI=1, t0=1 next clock.
REQ-037 With TIMING_WATCHDOG_EN, EXC at t3 and 16 idle cycles -> WDT_TO pulse, then FI=1, t0=1; without the macro, state held after 40 idle cycles and WDT_TO stays 0.
REQ-038 RST asserted during a DST wait state at t5 -> FI=1, t0=1 next clock, and TERR/WDT_TO stay 0.

Source files
------------

// File: rtl/timing_state_gen_pkg.sv
// rtl/timing_state_gen_pkg.sv - shared constants, cycle-state encodings and request priority helper
package timing_state_gen_pkg;

    // Number of beats in one machine cycle (t0..t11)
    localparam int BEAT_COUNT = 12;

    // One-hot beat vector with only t0 set
    localparam logic [BEAT_COUNT-1:0] BEAT_T0 = BEAT_COUNT'(1);

    // Watchdog idle counter width and the count at which the next idle cycle fires
    localparam int WDT_WIDTH = 4;
    localparam logic [WDT_WIDTH-1:0] WDT_LIMIT = 4'd15;

    // Machine-cycle state: one-hot while running, all-zero while halted
    typedef enum logic [3:0] {
        CYC_HALT = 4'b0000,
        CYC_FI   = 4'b0001,
        CYC_SRC  = 4'b0010,
        CYC_DST  = 4'b0100,
        CYC_EXC  = 4'b1000
    } cyc_state_t;

    // Highest-priority request wins (FI > SRC > DST > EXC); none keeps the current state
    function automatic cyc_state_t next_cycle(
        input logic       fi_req,
        input logic       src_req,
        input logic       dst_req,
        input logic       exc_req,
        input cyc_state_t cur
    );
        if (fi_req) begin
            return CYC_FI;
        end else if (src_req) begin
            return CYC_SRC;
        end else if (dst_req) begin
            return CYC_DST;
        end else if (exc_req) begin
            return CYC_EXC;
        end
        return cur;
    endfunction

endpackage

// File: rtl/timing_state_gen_beat_ring.sv
// rtl/timing_state_gen_beat_ring.sv - one-hot beat ring with restart, advance, hold, clear and overrun flag
module beat_ring
    import timing_state_gen_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  restart_i,
    input  logic                  advance_i,
    output logic [BEAT_COUNT-1:0] beat_o,
    output logic                  overrun_o
);

    logic [BEAT_COUNT-1:0] beat_q, beat_d;
    logic                  overrun_q, overrun_d;

    // Next beat: clear beats restart beats advance; advancing past t11 holds and flags overrun
    always_comb begin
        beat_d    = beat_q;
        overrun_d = 1'b0;
        if (clear_i) begin
            beat_d = '0;
        end else if (restart_i) begin
            beat_d = BEAT_T0;
        end else if (advance_i) begin
            if (beat_q[BEAT_COUNT-1]) begin
                overrun_d = 1'b1;
            end else begin
                beat_d = beat_q << 1;
            end
        end
    end

    // Beat and overrun registers; reset lands on t0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q    <= BEAT_T0;
            overrun_q <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            overrun_q <= overrun_d;
        end
    end

    assign beat_o    = beat_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/timing_state_gen.sv
// rtl/timing_state_gen.sv - beat and machine-cycle timing generator; optional idle watchdog under TIMING_WATCHDOG_EN
module timing_state_gen
    import timing_state_gen_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic T_0,
    input  logic T_1,
    input  logic FI0,
    input  logic SRC0,
    input  logic DST0,
    input  logic EXC0,
    input  logic HALT0,
    input  logic START,
    output logic t0,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic t4,
    output logic t5,
    output logic t6,
    output logic t7,
    output logic t8,
    output logic t9,
    output logic t10,
    output logic t11,
    output logic FI,
    output logic SRC,
    output logic DST,
    output logic EXC,
    output logic HALTED,
    output logic TERR,
    output logic WDT_TO
);

    cyc_state_t            cyc_q;
    logic                  halted;
    logic                  wdt_fire;
    logic                  ring_clear;
    logic                  ring_restart;
    logic                  ring_advance;
    logic [BEAT_COUNT-1:0] beat;

    assign halted = (cyc_q == CYC_HALT);

`ifdef TIMING_WATCHDOG_EN
    logic                 wdt_idle;
    logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
    logic                 wdt_to_q;

    // A cycle counts as idle only when running with no beat request and no START
    assign wdt_idle = !halted && !T_0 && !T_1 && !START;
    assign wdt_fire = wdt_idle && (wdt_cnt_q == WDT_LIMIT);

    // Idle count: grows on idle cycles, clears on any activity, halt, or firing
    always_comb begin
        wdt_cnt_d = '0;
        if (wdt_idle && !wdt_fire) begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end

    // Watchdog count and one-cycle timeout pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdt_cnt_q <= '0;
            wdt_to_q  <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_to_q  <= wdt_fire;
        end
    end

    assign WDT_TO = wdt_to_q;
`else
    assign wdt_fire = 1'b0;
    assign WDT_TO   = 1'b0;
`endif

    // Beat ring control mirrors the cycle-state decision: halted waits for START, T_0 beats T_1
    always_comb begin
        ring_clear   = 1'b0;
        ring_restart = 1'b0;
        ring_advance = 1'b0;
        if (halted) begin
            ring_restart = START;
        end else if (T_0) begin
            if (HALT0) begin
                ring_clear = 1'b1;
            end else begin
                ring_restart = 1'b1;
            end
        end else if (T_1) begin
            ring_advance = 1'b1;
        end else if (wdt_fire) begin
            ring_restart = 1'b1;
        end
    end

    // Machine-cycle state machine; the halt encoding doubles as the halted state
    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_q <= CYC_FI;
        end else if (halted) begin
            if (START) begin
                cyc_q <= CYC_FI;
            end
        end else if (T_0) begin
            if (HALT0) begin
                cyc_q <= CYC_HALT;
            end else begin
                cyc_q <= next_cycle(FI0, SRC0, DST0, EXC0, cyc_q);
            end
        end else if (wdt_fire) begin
            cyc_q <= CYC_FI;
        end
    end

    beat_ring u_beat_ring (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (ring_clear),
        .restart_i (ring_restart),
        .advance_i (ring_advance),
        .beat_o    (beat),
        .overrun_o (TERR)
    );

    assign {t11, t10, t9, t8, t7, t6, t5, t4, t3, t2, t1, t0} = beat;

    assign FI     = cyc_q[0];
    assign SRC    = cyc_q[1];
    assign DST    = cyc_q[2];
    assign EXC    = cyc_q[3];
    assign HALTED = halted;

endmodule
